// File: rtl/memwb_arbiter.sv
// Two-master Wishbone pipelined arbiter in front of the flash/memory slave.
// Master 0 is the QSPI controller and master 1 is the auxiliary master.
// Ownership is round-robin on ties and is never preempted. An owner that
// releases the bus with reads still outstanding leaves it in DRAIN until the
// slave has answered them all.

`ifndef NORADDRBITS
`define NORADDRBITS 24
`endif
`ifndef NORDATABITS
`define NORDATABITS 32
`endif

module memwb_arbiter #(
    parameter int ADDRBITS     = `NORADDRBITS,
    parameter int DATABITS     = `NORDATABITS,
    parameter int INFLIGHTBITS = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [1:0]            m_cyc_i,
    input  logic [1:0]            m_stb_i,
    input  logic [1:0]            m_we_i,
    input  logic [2*ADDRBITS-1:0] m_adr_i,
    input  logic [2*DATABITS-1:0] m_dat_i,
    output logic [1:0]            m_stall_o,
    output logic [1:0]            m_ack_o,
    output logic [1:0]            m_err_o,
    output logic [DATABITS-1:0]   m_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDRBITS-1:0]   s_adr_o,
    output logic [DATABITS-1:0]   s_dat_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_stall_i,
    input  logic [DATABITS-1:0]   s_dat_i,
    output logic [1:0]            gnt_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

    state_t                  state, state_next;
    logic                    last_gnt, last_gnt_next;
    logic [INFLIGHTBITS-1:0] inflight, inflight_next;
    logic                    accept, retire;

    // Read data goes to both masters; only the owner gets the ack.
    assign m_dat_o = s_dat_i;

    // Bus routing: the owner drives the slave, everyone else sees stall.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        case (state)
            OWN0: begin
                s_cyc_o      = m_cyc_i[0];
                s_stb_o      = m_stb_i[0];
                s_we_o       = m_we_i[0];
                s_adr_o      = m_adr_i[0 +: ADDRBITS];
                s_dat_o      = m_dat_i[0 +: DATABITS];
                m_stall_o[0] = s_stall_i;
                m_ack_o[0]   = s_ack_i;
                m_err_o[0]   = s_err_i;
            end
            OWN1: begin
                s_cyc_o      = m_cyc_i[1];
                s_stb_o      = m_stb_i[1];
                s_we_o       = m_we_i[1];
                s_adr_o      = m_adr_i[ADDRBITS +: ADDRBITS];
                s_dat_o      = m_dat_i[DATABITS +: DATABITS];
                m_stall_o[1] = s_stall_i;
                m_ack_o[1]   = s_ack_i;
                m_err_o[1]   = s_err_i;
            end
            DRAIN: begin
                s_cyc_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Outstanding-request count, saturating at both ends.
    // A response with nothing outstanding is stray and must not be counted.
    always_comb begin
        accept        = s_stb_o && !s_stall_i;
        retire        = (s_ack_i || s_err_i) && (inflight != '0);
        inflight_next = inflight;
        if (accept && !retire && (inflight != '1))
            inflight_next = inflight + INFLIGHTBITS'(1);
        else if (!accept && retire)
            inflight_next = inflight - INFLIGHTBITS'(1);
    end

    // Ownership decisions. Release is judged on the post-update count, so a
    // final ack that arrives together with the cyc drop goes straight to IDLE.
    always_comb begin
        state_next    = state;
        last_gnt_next = last_gnt;
        case (state)
            IDLE: begin
                if (m_cyc_i == 2'b11) begin
                    state_next    = last_gnt ? OWN0 : OWN1;
                    last_gnt_next = !last_gnt;
                end else if (m_cyc_i[0]) begin
                    state_next    = OWN0;
                    last_gnt_next = 1'b0;
                end else if (m_cyc_i[1]) begin
                    state_next    = OWN1;
                    last_gnt_next = 1'b1;
                end
            end
            OWN0: if (!m_cyc_i[0]) state_next = (inflight_next == '0) ? IDLE : DRAIN;
            OWN1: if (!m_cyc_i[1]) state_next = (inflight_next == '0) ? IDLE : DRAIN;
            DRAIN: if (inflight_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, round-robin pointer, counter and registered grant/busy flags.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            inflight <= '0;
            gnt_o    <= '0;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
            inflight <= inflight_next;
            gnt_o    <= (state_next == OWN0) ? 2'b01 :
                        (state_next == OWN1) ? 2'b10 : 2'b00;
            busy_o   <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_memwb_arbiter.sv
// Directed bench for memwb_arbiter: single-master burst, round-robin ties,
// abort with drain, slave stall, error response, async reset and counter
// saturation.

module tb_memwb_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int IB = 3;

    logic            clk_i = 1'b0;
    logic            reset_ni = 1'b0;
    logic [1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [2*AW-1:0] m_adr_i;
    logic [2*DW-1:0] m_dat_i;
    logic [1:0]      m_stall_o, m_ack_o, m_err_o;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic            s_ack_i, s_err_i, s_stall_i;
    logic [DW-1:0]   s_dat_i;
    logic [1:0]      gnt_o;
    logic            busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    int acks  = 0;
    int errs  = 0;

    // Single-master burst: per-cycle stimulus and expected counter value
    logic [15:0] t1_adr [7] = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h0, 16'h0, 16'h0};
    int          t1_stb [7] = '{1, 1, 1, 1, 0, 0, 0};
    int          t1_ack [7] = '{0, 0, 1, 1, 1, 1, 0};
    int          t1_cyc [7] = '{1, 1, 1, 1, 1, 1, 0};
    int          t1_inf [7] = '{0, 1, 2, 2, 2, 1, 0};

    memwb_arbiter #(
        .ADDRBITS(AW),
        .DATABITS(DW),
        .INFLIGHTBITS(IB)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_stall_o(m_stall_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
        .s_dat_i(s_dat_i),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive just after the edge, let outputs settle.
    task automatic cyc_in(input logic [1:0] cyc, input logic [1:0] stb,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic ack, input logic err, input logic stall);
        @(posedge clk_i);
        #1;
        m_cyc_i   = cyc;
        m_stb_i   = stb;
        m_adr_i   = {a1, a0};
        s_ack_i   = ack;
        s_err_i   = err;
        s_stall_i = stall;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   gnt_o, 2'b00);
        check({tag, "_busy"},  busy_o, 1'b0);
        check({tag, "_scyc"},  s_cyc_o, 1'b0);
        check({tag, "_sstb"},  s_stb_o, 1'b0);
        check({tag, "_ack"},   m_ack_o, 2'b00);
        check({tag, "_err"},   m_err_o, 2'b00);
        check({tag, "_stall"}, m_stall_o, 2'b11);
        check({tag, "_infl"},  dut.inflight, 0);
    endtask

    initial begin
        m_cyc_i = '0; m_stb_i = '0; m_we_i = 2'b10;
        m_adr_i = '0; m_dat_i = {16'h2222, 16'h1111};
        s_ack_i = 1'b0; s_err_i = 1'b0; s_stall_i = 1'b0;
        s_dat_i = 16'hA5A5;

        #3;
        check_reset_outputs("rst");
        check("rdata_bcast", m_dat_o, 16'hA5A5);
        #19 reset_ni = 1'b1;

        // ---- single master, 4 pipelined reads, ack latency 2
        cyc_in(2'b01, 2'b01, 16'h10, 16'h0, 0, 0, 0);
        check("t1_idle_gnt", gnt_o, 2'b00);
        check("t1_idle_sstb", s_stb_o, 1'b0);
        check("t1_idle_stall", m_stall_o, 2'b11);
        for (int i = 0; i < 7; i++) begin
            cyc_in({1'b0, t1_cyc[i][0]}, {1'b0, t1_stb[i][0]}, t1_adr[i], 16'h0,
                   t1_ack[i][0], 0, 0);
            check($sformatf("t1_gnt%0d", i), gnt_o, 2'b01);
            check($sformatf("t1_infl%0d", i), dut.inflight, t1_inf[i]);
            if (t1_stb[i] != 0) check($sformatf("t1_adr%0d", i), s_adr_o, t1_adr[i]);
            acks += int'(m_ack_o[0]);
        end
        check("t1_we", s_we_o, 1'b0);
        check("t1_sdat", s_dat_o, 16'h1111);
        // stray ack in IDLE: not forwarded, not counted
        cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 1, 0, 0);
        check("t1_ack_count", acks, 4);
        check("t1_end_gnt", gnt_o, 2'b00);
        check("t1_end_busy", busy_o, 1'b0);
        check("stray_ack_idle", m_ack_o, 2'b00);
        cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("stray_ack_infl", dut.inflight, 0);

        // ---- ties and round robin, starting from reset
        @(negedge clk_i) reset_ni = 1'b0;
        @(negedge clk_i) reset_ni = 1'b1;
        cyc_in(2'b11, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("tie_idle", gnt_o, 2'b00);
        cyc_in(2'b11, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("tie1_m0", gnt_o, 2'b01);
        cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("rel0_still_own", gnt_o, 2'b01);
        cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("gap_gnt", gnt_o, 2'b00);
        check("gap_busy", busy_o, 1'b0);
        cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("m1_gnt", gnt_o, 2'b10);
        check("m1_we", s_we_o, 1'b1);
        check("m1_sdat", s_dat_o, 16'h2222);
        cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        cyc_in(2'b11, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("tie2_idle", gnt_o, 2'b00);
        cyc_in(2'b11, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("tie2_m0", gnt_o, 2'b01);

        // ---- abort with 3 outstanding reads, master 1 waiting
        cyc_in(2'b11, 2'b01, 16'h40, 16'h0, 0, 0, 0);
        cyc_in(2'b11, 2'b01, 16'h41, 16'h0, 0, 0, 0);
        cyc_in(2'b11, 2'b01, 16'h42, 16'h0, 0, 0, 0);
        check("ab_stall_m1", m_stall_o, 2'b10);
        cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("ab_drop_infl", dut.inflight, 3);
        for (int i = 0; i < 3; i++) begin
            cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 1, 0, 0);
            check($sformatf("dr_gnt%0d", i), gnt_o, 2'b00);
            check($sformatf("dr_busy%0d", i), busy_o, 1'b1);
            check($sformatf("dr_scyc%0d", i), s_cyc_o, 1'b1);
            check($sformatf("dr_sstb%0d", i), s_stb_o, 1'b0);
            check($sformatf("dr_ack%0d", i), m_ack_o, 2'b00);
            check($sformatf("dr_stall%0d", i), m_stall_o, 2'b11);
            check($sformatf("dr_infl%0d", i), dut.inflight, 3 - i);
        end
        cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("dr_idle_gnt", gnt_o, 2'b00);
        check("dr_idle_busy", busy_o, 1'b0);
        cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("dr_m1_gnt", gnt_o, 2'b10);

        // ---- slave stall during OWN1
        for (int i = 0; i < 5; i++) begin
            cyc_in(2'b10, 2'b10, 16'h0, 16'h20, 0, 0, 1);
            check($sformatf("st_stall%0d", i), m_stall_o, 2'b11);
            check($sformatf("st_adr%0d", i), s_adr_o, 16'h20);
            check($sformatf("st_infl%0d", i), dut.inflight, 0);
        end
        cyc_in(2'b10, 2'b10, 16'h0, 16'h20, 0, 0, 0);
        check("st_free", m_stall_o, 2'b01);
        cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 1, 0, 0);
        check("st_infl_acc", dut.inflight, 1);
        check("st_ack", m_ack_o, 2'b10);

        // ---- error on the 2nd of 3 requests
        errs = 0;
        cyc_in(2'b10, 2'b10, 16'h0, 16'h30, 0, 0, 0);
        check("er_infl0", dut.inflight, 0);
        cyc_in(2'b10, 2'b10, 16'h0, 16'h31, 0, 0, 0);
        cyc_in(2'b10, 2'b10, 16'h0, 16'h32, 1, 0, 0);
        check("er_ack1", m_ack_o, 2'b10);
        errs += int'(m_err_o[1]);
        cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 0, 1, 0);
        check("er_err", m_err_o, 2'b10);
        check("er_noack", m_ack_o, 2'b00);
        check("er_infl_before", dut.inflight, 2);
        errs += int'(m_err_o[1]);
        cyc_in(2'b10, 2'b00, 16'h0, 16'h0, 1, 0, 0);
        check("er_infl_after", dut.inflight, 1);
        errs += int'(m_err_o[1]);
        cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("er_infl_done", dut.inflight, 0);
        errs += int'(m_err_o[1]);
        check("er_pulses", errs, 1);
        cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("er_idle", gnt_o, 2'b00);

        // ---- async reset mid-OWN0 with 2 outstanding
        cyc_in(2'b01, 2'b01, 16'h50, 16'h0, 0, 0, 0);
        cyc_in(2'b01, 2'b01, 16'h50, 16'h0, 0, 0, 0);
        cyc_in(2'b01, 2'b01, 16'h51, 16'h0, 0, 0, 0);
        cyc_in(2'b01, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("ar_pre_infl", dut.inflight, 2);
        check("ar_pre_gnt", gnt_o, 2'b01);
        #1 reset_ni = 1'b0;
        #1;
        check_reset_outputs("ar");
        m_cyc_i = '0;
        @(negedge clk_i) reset_ni = 1'b1;
        cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 1, 0, 0);
        check("ar_late_ack", m_ack_o, 2'b00);
        cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("ar_late_infl", dut.inflight, 0);

        // ---- counter saturation (INFLIGHTBITS=3 -> 7), then full drain
        cyc_in(2'b01, 2'b01, 16'h60, 16'h0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc_in(2'b01, 2'b01, 16'h60, 16'h0, 0, 0, 0);
            check($sformatf("sat_infl%0d", i), dut.inflight, (i < 7) ? i : 7);
        end
        cyc_in(2'b01, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("sat_max", dut.inflight, 7);
        cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 1, 0, 0);
            check($sformatf("sd_busy%0d", i), busy_o, 1'b1);
            check($sformatf("sd_infl%0d", i), dut.inflight, 7 - i);
        end
        cyc_in(2'b00, 2'b00, 16'h0, 16'h0, 0, 0, 0);
        check("sd_idle", busy_o, 1'b0);
        check("sd_zero", dut.inflight, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memwb_arbiter.md
MEMWB_ARBITER -- requirements
Module: memwb_arbiter

Interface
REQ-001 Parameters SHALL be: ADDRBITS, default `NORADDRBITS, memory address width; DATABITS, default `NORDATABITS, memory data width; INFLIGHTBITS, default 5, outstanding-request counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i  in  1  system clock
- reset_ni  in  1  reset, asynchronous, active-low
- m_cyc_i  in  2  per-master cycle; bit 0 = QSPI controller, bit 1 = auxiliary master
- m_stb_i  in  2  per-master strobe
- m_we_i  in  2  per-master write enable
- m_adr_i  in  2*ADDRBITS  per-master address; master n in slice [n*ADDRBITS +: ADDRBITS]
- m_dat_i  in  2*DATABITS  per-master write data
- m_stall_o  out  2  per-master stall
- m_ack_o  out  2  per-master ack
- m_err_o  out  2  per-master error
- m_dat_o  out  DATABITS  read data, broadcast to both masters
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable
- s_adr_o  out  ADDRBITS  slave address
- s_dat_o  out  DATABITS  slave write data
- s_ack_i, s_err_i, s_stall_i  in  1 each  slave ack, error, stall
- s_dat_i  in  DATABITS  slave read data
- gnt_o  out  2  one-hot current owner; 00 when idle
- busy_o  out  1  arbiter not in IDLE
REQ-003 Clocking SHALL be one clock, clk_i; reset_ni SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, OWN0, OWN1, and DRAIN; state, last-grant register, and inflight counter SHALL be registered.
REQ-005 In IDLE, a master requests when m_cyc_i[n]=1; a single requester SHALL win, and the grant SHALL take effect the next cycle (state OWNn).
REQ-006 If both masters request in IDLE, the master not equal to last_gnt SHALL win (round-robin); last_gnt SHALL update on every grant.
REQ-007 In OWNn, s_cyc_o, s_stb_o, s_we_o, s_adr_o, and s_dat_o SHALL be combinational copies of master n's signals.
REQ-008 In OWNn, m_stall_o[n] SHALL equal s_stall_i, m_ack_o[n] SHALL equal s_ack_i, and m_err_o[n] SHALL equal s_err_i.
REQ-009 The non-owner SHALL see stall=1, ack=0, err=0; in IDLE both m_stall_o bits SHALL be 1.
REQ-010 m_dat_o SHALL equal s_dat_i in every state.
REQ-011 Accepted requests (s_stb_o && !s_stall_i) SHALL increment the inflight counter; (s_ack_i || s_err_i) SHALL decrement it.
- Simultaneous accept and ack: counter unchanged.
- Counter SHALL saturate at 2^INFLIGHTBITS-1 and at 0; it never wraps.
REQ-012 Owner drops m_cyc_i with inflight=0, and no ack/err that cycle leaves it nonzero: the next state SHALL be IDLE.
REQ-013 Owner drops m_cyc_i with inflight>0: the next state SHALL be DRAIN. In DRAIN:
- s_cyc_o=1, s_stb_o=0.
- slave acks/errs decrement the counter but are not forwarded (m_ack_o=m_err_o=00).
- both masters stalled.
- transition to IDLE on the cycle the counter reaches 0.
REQ-014 An ack/err arriving with inflight=0 in any state SHALL be forwarded only in OWNn and SHALL NOT change the counter.
REQ-015 The arbiter SHALL NOT preempt; an owner keeps the bus while its m_cyc_i stays high, regardless of the other master.
REQ-016 A master re-requesting in the same cycle as its release SHALL be handled as a new request after IDLE.
- IDLE lasts at least one cycle between grants.
REQ-017 gnt_o SHALL be 01 in OWN0, 10 in OWN1, and 00 otherwise; busy_o=1 in OWN0, OWN1, and DRAIN.

Reset
REQ-018 While reset_ni=0, the block SHALL hold: state=IDLE, last_gnt=1 (master 0 wins the first tie), inflight=0, gnt_o=00, busy_o=0, s_cyc_o=0, s_stb_o=0, m_ack_o=00, m_err_o=00, m_stall_o=11.
REQ-019 Assertion of reset_ni mid-transfer SHALL abort immediately, with outstanding slave acks after release treated per REQ-014.
REQ-020 Deassertion of reset_ni SHALL be synchronized by the instantiating level; the block samples no input during reset.

Verification
REQ-021 Single master: m_cyc_i=01, 4 pipelined reads at addr 0x10-0x13, slave ack latency 2 -> gnt_o=01 one cycle after request; 4 acks on m_ack_o[0]; s_adr_o sequence 0x10..0x13; IDLE after cyc drop.
REQ-022 Tie: both cyc rise together after reset -> master 0 granted first. Master 0 releases with the cyc of master 1 still high -> master 1 granted after exactly one IDLE cycle. A further tie -> master 0 wins again.
REQ-023 Abort with 3 outstanding reads: master 0 drops cyc -> DRAIN, s_stb_o=0, 3 acks absorbed (m_ack_o=00), IDLE the cycle inflight hits 0, then master 1 granted.
REQ-024 Stall: s_stall_i=1 for 5 cycles during OWN1 -> m_stall_o=11 throughout, inflight constant, no address advance at the slave.
REQ-025 Error: s_err_i pulse on the 2nd of 3 requests -> m_err_o[n] single pulse, inflight decrements as for ack, and completion proceeds normally.
REQ-026 Async reset: reset_ni=0 mid-OWN0 with 2 inflight -> all outputs take REQ-018 values within the same cycle, without a clock edge.
